bcd_updown_counter: RTL and testbench

- Parametrised multi-digit BCD counter. Successor to the up-only decimal counter.
- Adds up/down counting, synchronous parallel load, wrap or saturate mode, and a registered terminal-count pulse.
- Sits between the debounced pushbutton edge pulses and the display driver.
- Its `count_value` bus feeds the seven-segment mux unchanged (digit 0 in bits [3:0]).

---
 rtl/bcd_pkg.sv | 9 +
 rtl/bcd_digit.sv | 25 ++
 rtl/bcd_updown_counter.sv | 75 +++++++
 tb/tb_bcd_updown_counter.sv | 118 +++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, bounds and validity helper
package bcd_pkg;
    typedef logic [3:0] digit_t;
    localparam digit_t BCD_MAX = 4'd9;
    localparam digit_t BCD_MIN = 4'd0;
    function automatic logic is_bcd(digit_t d);
        return d <= BCD_MAX;
    endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit register with load and wrapping up/down step
module bcd_digit
    import bcd_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   step,
    input  logic   up,
    input  logic   ld,
    input  digit_t ld_val,
    output digit_t q,
    output logic   at_max,
    output logic   at_min
);
    assign at_max = q == BCD_MAX;
    assign at_min = q == BCD_MIN;
    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= BCD_MIN;
        else if (ld)
            q <= ld_val;
        else if (step)
            q <= up ? (at_max ? BCD_MIN : q + 4'd1) : (at_min ? BCD_MAX : q - 4'd1);
    end
endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit BCD up/down counter; BCD_COUNTER_LOAD_CHECK_EN rejects non-BCD loads
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS    = 6,
    parameter int BCD_WIDTH = DIGITS * 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 up,
    input  logic                 sat,
    input  logic                 load,
    input  logic [BCD_WIDTH-1:0] load_value,
    output logic [BCD_WIDTH-1:0] count_value,
    output logic                 tc,
    output logic                 is_zero,
    output logic                 load_err
);
    logic [DIGITS-1:0] at_max, at_min, step;
    logic ld, at_bound, cnt_en;
`ifdef BCD_COUNTER_LOAD_CHECK_EN
    logic [DIGITS-1:0] bad;
`endif
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        digit_t d_ld;
`ifdef BCD_COUNTER_LOAD_CHECK_EN
        assign bad[i] = !is_bcd(load_value[4*i+:4]);
        assign d_ld   = load_value[4*i+:4];
`else
        assign d_ld = is_bcd(load_value[4*i+:4]) ? load_value[4*i+:4] : BCD_MAX;
`endif
        bcd_digit u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .step   (step[i]),
            .up     (up),
            .ld     (ld),
            .ld_val (d_ld),
            .q      (count_value[4*i+:4]),
            .at_max (at_max[i]),
            .at_min (at_min[i])
        );
    end
`ifdef BCD_COUNTER_LOAD_CHECK_EN
    assign ld = load && !(|bad);
`else
    assign ld = load;
    assign load_err = 1'b0;
`endif
    assign is_zero  = &at_min;
    assign at_bound = up ? &at_max : &at_min;
    // saturating at a bound simply withholds the step from every digit
    assign cnt_en   = ce && !load && !(sat && at_bound);
    always_comb begin
        step    = '0;
        step[0] = cnt_en;
        for (int k = 1; k < DIGITS; k++)
            step[k] = step[k-1] && (up ? at_max[k-1] : at_min[k-1]);
    end
    always_ff @(posedge clk) begin
        if (!rst_n)
            tc <= 1'b0;
        else
            tc <= ce && !load && at_bound;
    end
`ifdef BCD_COUNTER_LOAD_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            load_err <= 1'b0;
        else
            load_err <= load && (|bad);
    end
`endif
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: table-driven checks of the BCD up/down counter
module tb_bcd_updown_counter;
`ifdef BCD_COUNTER_LOAD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    typedef struct {
        logic       rst_n, ce, up, sat, load;
        logic [7:0] lv;
        logic [7:0] q;
        logic       tc, z, err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, ce, up, sat, load;
    logic [7:0] load_value, count_value;
    logic tc, is_zero, load_err;
    logic rst_n6, ce6, up6, sat6, load6;
    logic [23:0] load_value6, count_value6;
    logic tc6, is_zero6, load_err6;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .up(up), .sat(sat), .load(load),
        .load_value(load_value), .count_value(count_value), .tc(tc),
        .is_zero(is_zero), .load_err(load_err)
    );

    bcd_updown_counter #(.DIGITS(6)) dut6 (
        .clk(clk), .rst_n(rst_n6), .ce(ce6), .up(up6), .sat(sat6), .load(load6),
        .load_value(load_value6), .count_value(count_value6), .tc(tc6),
        .is_zero(is_zero6), .load_err(load_err6)
    );

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic c, input logic u, input logic s,
                         input logic l, input logic [7:0] lv);
        rst_n = r; ce = c; up = u; sat = s; load = l; load_value = lv;
        @(posedge clk);
        #1;
    endtask

    vec_t v[20];

    initial begin
        int n;
        logic [7:0] eq;
        rst_n6 = 1'b0; ce6 = 1'b0; up6 = 1'b1; sat6 = 1'b0; load6 = 1'b0; load_value6 = '0;
        //          rst  ce   up   sat  load lv     q      tc   z    err
        v[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 8'h00, 1'b0, 1'b1, 1'b0};
        v[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        v[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 1'b1, 1'b0, 1'b0};
        v[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h98, 1'b0, 1'b0, 1'b0};
        v[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h98, 1'b0, 1'b0, 1'b0};
        v[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h99, 8'h99, 1'b0, 1'b0, 1'b0};
        v[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1, 1'b0, 1'b0};
        v[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1, 1'b0, 1'b0};
        v[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1, 1'b0, 1'b0};
        v[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h98, 1'b0, 1'b0, 1'b0};
        v[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h42, 8'h42, 1'b0, 1'b0, 1'b0};
        v[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h4A, CHK ? 8'h42 : 8'h49, 1'b0, 1'b0, CHK};
        v[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, CHK ? 8'h42 : 8'h49, 1'b0, 1'b0, 1'b0};
        v[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
        v[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        v[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
        v[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 1'b1, 1'b0, 1'b0};
        v[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 8'h99, 1'b0, 1'b0, 1'b0};
        v[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        v[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF5, CHK ? 8'h00 : 8'h95, 1'b0, CHK, CHK};
        for (int i = 0; i < 20; i++) begin
            drive(v[i].rst_n, v[i].ce, v[i].up, v[i].sat, v[i].load, v[i].lv);
            check($sformatf("vec%0d count", i), 24'(count_value), 24'(v[i].q));
            check($sformatf("vec%0d tc", i), 24'(tc), 24'(v[i].tc));
            check($sformatf("vec%0d is_zero", i), 24'(is_zero), 24'(v[i].z));
            check($sformatf("vec%0d load_err", i), 24'(load_err), 24'(v[i].err));
        end
        // full up sweep with wrap: 100 steps from 0 returns to 0
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
            n = (n + 1) % 100;
            eq = {4'(n / 10), 4'(n % 10)};
            check($sformatf("sweep%0d count", i), 24'(count_value), 24'(eq));
            check($sformatf("sweep%0d tc", i), 24'(tc), 24'(n == 0));
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("sweep idle tc", 24'(tc), 24'(0));
        // six-digit instance: long carry chain and full wrap
        @(posedge clk); #1;
        rst_n6 = 1'b1; load6 = 1'b1; load_value6 = 24'h009999;
        @(posedge clk); #1;
        load6 = 1'b0; ce6 = 1'b1;
        @(posedge clk); #1;
        check("d6 carry count", count_value6, 24'h010000);
        check("d6 carry tc", 24'(tc6), 24'(0));
        ce6 = 1'b0; load6 = 1'b1; load_value6 = 24'h999999;
        @(posedge clk); #1;
        load6 = 1'b0; ce6 = 1'b1;
        @(posedge clk); #1;
        check("d6 wrap count", count_value6, 24'h000000);
        check("d6 wrap tc", 24'(tc6), 24'(1));
        check("d6 wrap is_zero", 24'(is_zero6), 24'(1));
        ce6 = 1'b0;
        @(posedge clk); #1;
        check("d6 idle tc", 24'(tc6), 24'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
